exception_ctrl: RTL and testbench

EXCEPTION_CTRL -- requirements
Module: exception_ctrl

---
 rtl/exception_ctrl.sv | 93 +++++++++
 tb/tb_exception_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exception_ctrl.sv
// Exception sequencer: saves EPC/cause, fetches the handler vector byte
// from memory and redirects the PC with a one-cycle load strobe.
module exception_ctrl #(
   parameter int MEM_WAIT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        exc_opcode,
   input  logic        exc_overflow,
   input  logic        exc_divzero,
   input  logic [31:0] pc_in,
   input  logic [7:0]  mem_byte,
   input  logic [2:0]  memtoreg_in,
   input  logic        regwrite_in,
   output logic [2:0]  memtoreg_out,
   output logic        regwrite_out,
   output logic        busy,
   output logic [31:0] epc,
   output logic [1:0]  cause,
   output logic        mem_read,
   output logic [31:0] mem_addr,
   output logic        pc_load,
   output logic [31:0] pc_next,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, SAVE, READ, LOAD} state_t;

   localparam logic [3:0] LAST = 4'(MEM_WAIT - 1);

   state_t      state;
   state_t      nxt;
   logic [3:0]  cnt;
   logic        any_exc;
   logic [1:0]  cause_nxt;

   assign any_exc = exc_opcode | exc_overflow | exc_divzero;

   // Overlapping flags are legal, so this must be a priority decode.
   always_comb begin
      cause_nxt = 2'd0;
      priority case (1'b1)
         exc_opcode:   cause_nxt = 2'd1;
         exc_overflow: cause_nxt = 2'd2;
         exc_divzero:  cause_nxt = 2'd3;
         default:      cause_nxt = 2'd0;
      endcase
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    if (any_exc) nxt = SAVE;
         SAVE:    nxt = READ;
         READ:    if (cnt == LAST) nxt = LOAD;
         LOAD:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         epc     <= 32'd0;
         cause   <= 2'd0;
         pc_next <= 32'd0;
      end else begin
         state <= nxt;
         if (state == IDLE && any_exc) begin
            cause <= cause_nxt;
            epc   <= pc_in;
         end
         if (state == READ) cnt <= cnt + 4'd1;
         else               cnt <= 4'd0;
         // Vector byte is taken on the edge that enters LOAD.
         if (state == READ && cnt == LAST)
            pc_next <= {24'd0, mem_byte};
      end
   end

   assign busy     = (state != IDLE);
   assign mem_read = (state == READ);
   assign pc_load  = (state == LOAD);
   assign done     = (state == LOAD);
   // Vectors 253..255 are 0xFC | cause.
   assign mem_addr = (state == SAVE || state == READ)
                   ? {24'd0, 6'b111111, cause} : 32'd0;

   assign memtoreg_out = busy ? 3'd0 : memtoreg_in;
   assign regwrite_out = regwrite_in & ~busy & ~any_exc;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl; two instances (MEM_WAIT 1 and 3)
// share the same stimulus.
module tb_exception_ctrl;

   logic        clk;
   logic        reset;
   logic        exc_op, exc_ov, exc_dz;
   logic [31:0] pc_in;
   logic [7:0]  mem_byte;
   logic [2:0]  mt_in;
   logic        rw_in;

   logic [2:0]  mt1, mt3;
   logic        rw1, rw3, busy1, busy3;
   logic [31:0] epc1, epc3, ma1, ma3, pn1, pn3;
   logic [1:0]  cause1, cause3;
   logic        mr1, mr3, pl1, pl3, dn1, dn3;

   int tests = 0;
   int fails = 0;

   exception_ctrl #(.MEM_WAIT(1)) dut1 (
      .clk(clk), .reset(reset),
      .exc_opcode(exc_op), .exc_overflow(exc_ov), .exc_divzero(exc_dz),
      .pc_in(pc_in), .mem_byte(mem_byte),
      .memtoreg_in(mt_in), .regwrite_in(rw_in),
      .memtoreg_out(mt1), .regwrite_out(rw1), .busy(busy1),
      .epc(epc1), .cause(cause1), .mem_read(mr1), .mem_addr(ma1),
      .pc_load(pl1), .pc_next(pn1), .done(dn1)
   );

   exception_ctrl #(.MEM_WAIT(3)) dut3 (
      .clk(clk), .reset(reset),
      .exc_opcode(exc_op), .exc_overflow(exc_ov), .exc_divzero(exc_dz),
      .pc_in(pc_in), .mem_byte(mem_byte),
      .memtoreg_in(mt_in), .regwrite_in(rw_in),
      .memtoreg_out(mt3), .regwrite_out(rw3), .busy(busy3),
      .epc(epc3), .cause(cause3), .mem_read(mr3), .mem_addr(ma3),
      .pc_load(pl3), .pc_next(pn3), .done(dn3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [2:0]  flags;
      logic [31:0] pc;
      logic [7:0]  mb;
      logic [2:0]  mt;
      logic        rw;
      logic [1:0]  cause;
      logic [31:0] addr;
      logic [31:0] pcn;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic set_flags(input logic [2:0] f);
      {exc_op, exc_ov, exc_dz} = f;
   endtask

   task automatic run_vec(input int i);
      int l1, l3, m1, m3, d1, d3;
      l1 = 0; l3 = 0; m1 = 0; m3 = 0; d1 = 0; d3 = 0;
      @(negedge clk);
      set_flags(vecs[i].flags);
      pc_in = vecs[i].pc;
      mem_byte = vecs[i].mb;
      mt_in = vecs[i].mt;
      rw_in = vecs[i].rw;
      #1;
      chk($sformatf("v%0d rw_fault", i), 32'(rw1), 32'd0);
      chk($sformatf("v%0d mt_idle", i), 32'(mt1), 32'(vecs[i].mt));
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 1) begin
            chk($sformatf("v%0d busy", i), 32'(busy1), 32'd1);
            chk($sformatf("v%0d cause", i), 32'(cause1), 32'(vecs[i].cause));
            chk($sformatf("v%0d epc", i), epc1, vecs[i].pc);
            chk($sformatf("v%0d addr1", i), ma1, vecs[i].addr);
            chk($sformatf("v%0d addr3", i), ma3, vecs[i].addr);
            chk($sformatf("v%0d mt_busy", i), 32'(mt1), 32'd0);
            set_flags(3'b000);
         end
         if (c == 2) begin
            #1;
            chk($sformatf("v%0d rw_busy", i), 32'(rw3), 32'd0);
            chk($sformatf("v%0d addr_rd", i), ma3, vecs[i].addr);
         end
         if (mr1) m1++;
         if (mr3) m3++;
         if (pl1) l1 = c;
         if (pl3) l3 = c;
         if (dn1) d1++;
         if (dn3) d3++;
      end
      chk($sformatf("v%0d load_cyc1", i), 32'(l1), 32'd3);
      chk($sformatf("v%0d load_cyc3", i), 32'(l3), 32'd5);
      chk($sformatf("v%0d rd_cnt1", i), 32'(m1), 32'd1);
      chk($sformatf("v%0d rd_cnt3", i), 32'(m3), 32'd3);
      chk($sformatf("v%0d done1", i), 32'(d1), 32'd1);
      chk($sformatf("v%0d done3", i), 32'(d3), 32'd1);
      chk($sformatf("v%0d pcn1", i), pn1, vecs[i].pcn);
      chk($sformatf("v%0d pcn3", i), pn3, vecs[i].pcn);
      chk($sformatf("v%0d idle", i), 32'(busy3), 32'd0);
      chk($sformatf("v%0d cause_hold", i), 32'(cause3),
          32'(vecs[i].cause));
      chk($sformatf("v%0d epc_hold", i), epc1, vecs[i].pc);
      chk($sformatf("v%0d addr_idle", i), ma1, 32'd0);
      chk($sformatf("v%0d rw_idle", i), 32'(rw1), 32'(vecs[i].rw));
      chk($sformatf("v%0d mt_back", i), 32'(mt3), 32'(vecs[i].mt));
   endtask

   initial begin
      int d1, d3, l3;
      vecs[0] = '{3'b010, 32'h0000_0040, 8'h8C, 3'd1, 1'b1,
                  2'd2, 32'd254, 32'h0000_008C};
      vecs[1] = '{3'b101, 32'h0000_1234, 8'h10, 3'd2, 1'b1,
                  2'd1, 32'd253, 32'h0000_0010};
      vecs[2] = '{3'b001, 32'hDEAD_BEEC, 8'hFF, 3'd1, 1'b1,
                  2'd3, 32'd255, 32'h0000_00FF};
      vecs[3] = '{3'b111, 32'h0000_0008, 8'h00, 3'd7, 1'b0,
                  2'd1, 32'd253, 32'h0000_0000};
      vecs[4] = '{3'b011, 32'hFFFF_FFFC, 8'h5A, 3'd4, 1'b1,
                  2'd2, 32'd254, 32'h0000_005A};

      reset = 1'b0;
      set_flags(3'b000);
      pc_in = 32'h0;
      mem_byte = 8'h0;
      mt_in = 3'd5;
      rw_in = 1'b1;
      @(negedge clk);
      chk("rst busy", 32'(busy1), 32'd0);
      chk("rst epc", epc3, 32'd0);
      chk("rst cause", 32'(cause1), 32'd0);
      chk("rst pcn", pn3, 32'd0);
      chk("rst rd_ld_dn", {29'd0, mr1, pl1, dn1}, 32'd0);
      chk("rst addr", ma1, 32'd0);
      chk("rst mt", 32'(mt1), 32'd5);
      chk("rst rw", 32'(rw1), 32'd1);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 5; i++) run_vec(i);

      // Second flag during READ is dropped
      d1 = 0; d3 = 0;
      @(negedge clk);
      set_flags(3'b010);
      pc_in = 32'h100;
      mem_byte = 8'h22;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 1) set_flags(3'b000);
         if (c == 3) set_flags(3'b100);
         if (c == 4) set_flags(3'b000);
         if (dn1) d1++;
         if (dn3) d3++;
      end
      chk("ign cause3", 32'(cause3), 32'd2);
      chk("ign cause1", 32'(cause1), 32'd2);
      chk("ign done3", 32'(d3), 32'd1);
      chk("ign done1", 32'(d1), 32'd1);
      chk("ign pcn3", pn3, 32'h22);

      // Flag in the first IDLE cycle restarts immediately
      d1 = 0; d3 = 0;
      @(negedge clk);
      set_flags(3'b010);
      pc_in = 32'h200;
      mem_byte = 8'h33;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 1) set_flags(3'b000);
         if (c == 4) begin
            set_flags(3'b001);
            pc_in = 32'h300;
         end
         if (c == 5) begin
            chk("b2b busy", 32'(busy1), 32'd1);
            chk("b2b cause", 32'(cause1), 32'd3);
            chk("b2b epc", epc1, 32'h300);
            chk("b2b addr", ma1, 32'd255);
            chk("b2b cause3", 32'(cause3), 32'd2);
            set_flags(3'b000);
            mem_byte = 8'h44;
         end
         if (dn1) d1++;
         if (dn3) d3++;
      end
      chk("b2b done1", 32'(d1), 32'd2);
      chk("b2b done3", 32'(d3), 32'd1);
      chk("b2b pcn1", pn1, 32'h44);
      chk("b2b pcn3", pn3, 32'h33);

      // Reset during READ aborts without a PC load
      l3 = 0;
      @(negedge clk);
      set_flags(3'b010);
      pc_in = 32'h500;
      mem_byte = 8'h66;
      mt_in = 3'd6;
      rw_in = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         if (c == 1) set_flags(3'b000);
         if (pl3) l3++;
      end
      chk("abort pre_rd", 32'(mr3), 32'd1);
      reset = 1'b0;
      #1;
      chk("abort busy", 32'(busy3), 32'd0);
      chk("abort rd_ld_dn", {29'd0, mr3, pl3, dn3}, 32'd0);
      chk("abort addr", ma3, 32'd0);
      chk("abort epc", epc3, 32'd0);
      chk("abort cause", 32'(cause3), 32'd0);
      chk("abort pcn", pn1, 32'd0);
      chk("abort mt", 32'(mt3), 32'd6);
      chk("abort rw", 32'(rw3), 32'd1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (pl3) l3++;
      end
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (pl3) l3++;
      end
      chk("abort no_load", 32'(l3), 32'd0);
      run_vec(0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
